// File: rtl/ds2411_id_sequencer.sv
// Sequences a read_ds2411 reader to fetch the board ROM ID, validates it, retries on failure.
// Optional macro DS2411_ID_CRC_CHECK_EN enables the serial Dallas CRC-8 check in CHK.
module ds2411_id_sequencer #(
    parameter int unsigned CLK_PER_US = 100,
    parameter logic [7:0]  FAMILY     = 8'h01,
    parameter int unsigned MAX_TRIES  = 3,
    parameter int unsigned TIMEOUT_US = 20000,
    parameter int unsigned GAP_US     = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        rd_go,
    input  logic        rd_working,
    input  logic        rd_done,
    input  logic        rd_error,
    input  logic [63:0] rd_result,
    output logic [47:0] serial,
    output logic [7:0]  family,
    output logic [7:0]  crc,
    output logic        valid,
    output logic        fail,
    output logic        busy,
    output logic [3:0]  tries,
    output logic [1:0]  err_code
);

    localparam logic [15:0] PRE_MAX     = 16'(CLK_PER_US - 1);
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_US);
    localparam logic [15:0] GAP_CNT     = 16'(GAP_US);
    localparam logic [3:0]  TRIES_MAX   = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RUN   = 3'd2,
        S_CHK   = 3'd3,
        S_RETRY = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        auto_q, auto_d;
    logic [47:0] serial_q, serial_d;
    logic [7:0]  family_q, family_d;
    logic [7:0]  crc_q, crc_d;
    logic        valid_q, valid_d;
    logic        fail_q, fail_d;
    logic        busy_q, busy_d;
    logic [3:0]  tries_q, tries_d;
    logic [1:0]  err_q, err_d;
    logic [63:0] rom_q, rom_d;

    // Reader lives in another tick domain: two-flop synchronizers on everything it drives
    logic [2:0]  ctl_s1_q, ctl_s2_q;
    logic [63:0] res_s1_q, res_s2_q;
    logic        working_s, done_s, error_s;

    logic [15:0] pre_q;
    logic [15:0] us_q;
    logic        timer_clr;
    logic        timeout;
    logic        gap_done;
    logic        check_done;
    logic        rom_ok;

`ifdef DS2411_ID_CRC_CHECK_EN
    logic [55:0] shift_q, shift_d;
    logic [7:0]  crc_acc_q, crc_acc_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        crc_fb;

    assign crc_fb     = crc_acc_q[0] ^ shift_q[0];
    assign check_done = (bit_cnt_q == 6'd56);
    assign rom_ok     = (crc_acc_q == rom_q[63:56]) && (rom_q[7:0] == FAMILY);
`else
    assign check_done = 1'b1;
    assign rom_ok     = (rom_q[7:0] == FAMILY);
`endif

    assign working_s = ctl_s2_q[0];
    assign done_s    = ctl_s2_q[1];
    assign error_s   = ctl_s2_q[2];
    assign timeout   = (us_q == TIMEOUT_CNT);
    assign gap_done  = (us_q == GAP_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            auto_q   <= 1'b1;
            serial_q <= '0;
            family_q <= '0;
            crc_q    <= '0;
            valid_q  <= 1'b0;
            fail_q   <= 1'b0;
            busy_q   <= 1'b0;
            tries_q  <= '0;
            err_q    <= '0;
            rom_q    <= '0;
            ctl_s1_q <= '0;
            ctl_s2_q <= '0;
            res_s1_q <= '0;
            res_s2_q <= '0;
            pre_q    <= '0;
            us_q     <= '0;
`ifdef DS2411_ID_CRC_CHECK_EN
            shift_q   <= '0;
            crc_acc_q <= '0;
            bit_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            auto_q   <= auto_d;
            serial_q <= serial_d;
            family_q <= family_d;
            crc_q    <= crc_d;
            valid_q  <= valid_d;
            fail_q   <= fail_d;
            busy_q   <= busy_d;
            tries_q  <= tries_d;
            err_q    <= err_d;
            rom_q    <= rom_d;
            ctl_s1_q <= {rd_error, rd_done, rd_working};
            ctl_s2_q <= ctl_s1_q;
            res_s1_q <= rd_result;
            res_s2_q <= res_s1_q;
`ifdef DS2411_ID_CRC_CHECK_EN
            shift_q   <= shift_d;
            crc_acc_q <= crc_acc_d;
            bit_cnt_q <= bit_cnt_d;
`endif
            // Shared microsecond timer: watchdog in REQ/RUN, inter-attempt gap in RETRY
            if (timer_clr) begin
                pre_q <= '0;
                us_q  <= '0;
            end else if (pre_q == PRE_MAX) begin
                pre_q <= '0;
                if (us_q != 16'hFFFF) begin
                    us_q <= us_q + 16'd1;
                end
            end else begin
                pre_q <= pre_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        auto_d    = auto_q;
        serial_d  = serial_q;
        family_d  = family_q;
        crc_d     = crc_q;
        valid_d   = valid_q;
        fail_d    = fail_q;
        busy_d    = busy_q;
        tries_d   = tries_q;
        err_d     = err_q;
        rom_d     = rom_q;
        timer_clr = 1'b0;
`ifdef DS2411_ID_CRC_CHECK_EN
        shift_d   = shift_q;
        crc_acc_d = crc_acc_q;
        bit_cnt_d = bit_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start || auto_q) begin
                    state_d   = S_REQ;
                    auto_d    = 1'b0;
                    busy_d    = 1'b1;
                    fail_d    = 1'b0;
                    tries_d   = 4'd1;
                    timer_clr = 1'b1;
                end
            end
            S_REQ, S_RUN: begin
                if (timeout) begin
                    err_d     = 2'd3;
                    state_d   = S_RETRY;
                    timer_clr = 1'b1;
                end else if (state_q == S_REQ) begin
                    if (working_s) begin
                        state_d = S_RUN;
                    end
                end else if (!working_s) begin
                    // A no-presence flag means the ROM bits are meaningless
                    if (done_s && !error_s) begin
                        state_d = S_CHK;
                        rom_d   = res_s2_q;
`ifdef DS2411_ID_CRC_CHECK_EN
                        shift_d   = res_s2_q[55:0];
                        crc_acc_d = '0;
                        bit_cnt_d = '0;
`endif
                    end else begin
                        err_d     = 2'd1;
                        state_d   = S_RETRY;
                        timer_clr = 1'b1;
                    end
                end
            end
            S_CHK: begin
                if (check_done) begin
                    if (rom_ok) begin
                        serial_d = rom_q[55:8];
                        family_d = rom_q[7:0];
                        crc_d    = rom_q[63:56];
                        valid_d  = 1'b1;
                        err_d    = 2'd0;
                        busy_d   = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        err_d     = 2'd2;
                        state_d   = S_RETRY;
                        timer_clr = 1'b1;
                    end
                end else begin
`ifdef DS2411_ID_CRC_CHECK_EN
                    // Dallas CRC-8, reflected form of x^8+x^5+x^4+1
                    crc_acc_d = {1'b0, crc_acc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
                    shift_d   = {1'b0, shift_q[55:1]};
                    bit_cnt_d = bit_cnt_q + 6'd1;
`endif
                end
            end
            S_RETRY: begin
                if (tries_q == TRIES_MAX) begin
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (gap_done) begin
                    tries_d   = tries_q + 4'd1;
                    state_d   = S_REQ;
                    timer_clr = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_go    = (state_q == S_REQ);
        serial   = serial_q;
        family   = family_q;
        crc      = crc_q;
        valid    = valid_q;
        fail     = fail_q;
        busy     = busy_q;
        tries    = tries_q;
        err_code = err_q;
    end

endmodule
